// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the data-memory port arbiter: the arbiter FSM
//   state encoding and the default parameter widths.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_t;

    localparam int ADDR_SIZE_DEF       = 16;
    localparam int WRITE_DATA_SIZE_DEF = 32;
    localparam int READ_DATA_SIZE_DEF  = 512;
    localparam int STARVE_LIMIT_DEF    = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one data-memory port between the CPU and the accelerator cluster.
//   One transaction at a time: IDLE -> ISSUE -> (read: CAPTURE -> RESP |
//   write: RESP) -> IDLE. The CPU normally wins; within one client a write
//   wins over a read.
//
//   Optional feature macro: MEM_PORT_ARBITER_STARVE_GUARD_EN
//     When defined, a starvation counter forces a cluster grant after
//     STARVE_LIMIT consecutive CPU grants with the cluster waiting.
//     When undefined, the CPU always wins and STARVE_LIMIT has no effect.
//
//   Ports
//     clk, rst                      clock, synchronous active-high reset
//     cpu_read_en/cpu_write_en      CPU request, held until its response
//     cpu_addr, cpu_write_data      CPU request address / write word
//     cpu_read_valid/cpu_write_done CPU one-cycle response pulses
//     acc_read_en/acc_write_en      cluster request, held until its response
//     acc_addr, acc_write_data      cluster request address / write word
//     acc_read_valid/acc_write_done cluster one-cycle response pulses
//     client_read_data              registered read line, shared by clients
//     mem_read_en/mem_write_en      data memory one-cycle strobes
//     mem_addr, mem_write_data      data memory address / write word
//     mem_read_data                 data memory line, valid cycle after read
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_SIZE       = ADDR_SIZE_DEF,
    parameter int WRITE_DATA_SIZE = WRITE_DATA_SIZE_DEF,
    parameter int READ_DATA_SIZE  = READ_DATA_SIZE_DEF,
    parameter int STARVE_LIMIT    = STARVE_LIMIT_DEF
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       cpu_read_en,
    input  logic                       cpu_write_en,
    input  logic [ADDR_SIZE-1:0]       cpu_addr,
    input  logic [WRITE_DATA_SIZE-1:0] cpu_write_data,
    output logic                       cpu_read_valid,
    output logic                       cpu_write_done,

    input  logic                       acc_read_en,
    input  logic                       acc_write_en,
    input  logic [ADDR_SIZE-1:0]       acc_addr,
    input  logic [WRITE_DATA_SIZE-1:0] acc_write_data,
    output logic                       acc_read_valid,
    output logic                       acc_write_done,

    output logic [READ_DATA_SIZE-1:0]  client_read_data,

    output logic                       mem_read_en,
    output logic                       mem_write_en,
    output logic [ADDR_SIZE-1:0]       mem_addr,
    output logic [WRITE_DATA_SIZE-1:0] mem_write_data,
    input  logic [READ_DATA_SIZE-1:0]  mem_read_data
);

    arb_state_t state;
    logic       grant_acc;   // registered grantee: 1 = cluster, 0 = CPU
    logic       op_write;    // registered operation: 1 = write, 0 = read

    logic cpu_req;
    logic acc_req;
    logic pick_acc;
    logic sel_write;
    logic [ADDR_SIZE-1:0]       sel_addr;
    logic [WRITE_DATA_SIZE-1:0] sel_wdata;

    assign cpu_req = cpu_read_en | cpu_write_en;
    assign acc_req = acc_read_en | acc_write_en;

`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             starve_hit;

    assign starve_hit = (starve_cnt == LIMIT_CNT);
    assign pick_acc   = acc_req & (~cpu_req | starve_hit);

    // Counter only moves on IDLE-cycle decisions; it clears whenever the
    // cluster is granted or is not asking, and saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (!acc_req || pick_acc) begin
                starve_cnt <= '0;
            end else if (!starve_hit) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`else
    assign pick_acc = acc_req & ~cpu_req;

    // STARVE_LIMIT has no role without the guard.
    logic unused_starve_limit;
    assign unused_starve_limit = |STARVE_LIMIT;
`endif

    assign sel_write = pick_acc ? acc_write_en   : cpu_write_en;
    assign sel_addr  = pick_acc ? acc_addr       : cpu_addr;
    assign sel_wdata = pick_acc ? acc_write_data : cpu_write_data;

    // Strobes are registered on the IDLE decision so they appear exactly
    // during the ISSUE cycle; pulses are registered one state ahead so they
    // appear exactly during RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            grant_acc        <= 1'b0;
            op_write         <= 1'b0;
            mem_read_en      <= 1'b0;
            mem_write_en     <= 1'b0;
            mem_addr         <= '0;
            mem_write_data   <= '0;
            cpu_read_valid   <= 1'b0;
            cpu_write_done   <= 1'b0;
            acc_read_valid   <= 1'b0;
            acc_write_done   <= 1'b0;
            client_read_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_req || acc_req) begin
                        grant_acc      <= pick_acc;
                        op_write       <= sel_write;
                        mem_addr       <= sel_addr;
                        mem_write_data <= sel_wdata;
                        mem_read_en    <= ~sel_write;
                        mem_write_en   <= sel_write;
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_read_en  <= 1'b0;
                    mem_write_en <= 1'b0;
                    if (op_write) begin
                        cpu_write_done <= ~grant_acc;
                        acc_write_done <= grant_acc;
                        state          <= ST_RESP;
                    end else begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    client_read_data <= mem_read_data;
                    cpu_read_valid   <= ~grant_acc;
                    acc_read_valid   <= grant_acc;
                    state            <= ST_RESP;
                end
                ST_RESP: begin
                    cpu_read_valid <= 1'b0;
                    cpu_write_done <= 1'b0;
                    acc_read_valid <= 1'b0;
                    acc_write_done <= 1'b0;
                    state          <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed, table-driven bench for mem_port_arbiter with a small
//   registered data-memory model. Honours MEM_PORT_ARBITER_STARVE_GUARD_EN
//   for the starvation sequence.
module tb_mem_port_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_read_en, cpu_write_en;
    logic [15:0]  cpu_addr;
    logic [31:0]  cpu_write_data;
    logic         cpu_read_valid, cpu_write_done;
    logic         acc_read_en, acc_write_en;
    logic [15:0]  acc_addr;
    logic [31:0]  acc_write_data;
    logic         acc_read_valid, acc_write_done;
    logic [511:0] client_read_data;
    logic         mem_read_en, mem_write_en;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_write_data;
    logic [511:0] mem_read_data = '0;

    int n_pass  = 0;
    int n_total = 0;
    logic [511:0] last_line;

    mem_port_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .cpu_read_en      (cpu_read_en),
        .cpu_write_en     (cpu_write_en),
        .cpu_addr         (cpu_addr),
        .cpu_write_data   (cpu_write_data),
        .cpu_read_valid   (cpu_read_valid),
        .cpu_write_done   (cpu_write_done),
        .acc_read_en      (acc_read_en),
        .acc_write_en     (acc_write_en),
        .acc_addr         (acc_addr),
        .acc_write_data   (acc_write_data),
        .acc_read_valid   (acc_read_valid),
        .acc_write_done   (acc_write_done),
        .client_read_data (client_read_data),
        .mem_read_en      (mem_read_en),
        .mem_write_en     (mem_write_en),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] line_for(input logic [15:0] a);
        logic [31:0] w;
        if (a == 16'h1000) return {64{8'hA5}};
        w = {a, ~a};
        return {16{w}};
    endfunction

    // Memory returns the addressed line the cycle after mem_read_en and a
    // junk pattern otherwise, so a mistimed capture shows up.
    always @(posedge clk) begin
        if (mem_read_en) mem_read_data <= line_for(mem_addr);
        else             mem_read_data <= {16{32'hBAD0_F00D}};
    end

    function automatic logic [3:0] pulses();
        return {cpu_read_valid, cpu_write_done, acc_read_valid, acc_write_done};
    endfunction

    function automatic logic [53:0] all_outs();
        return {pulses(), mem_read_en, mem_write_en, mem_addr, mem_write_data};
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction starting with the DUT in IDLE and the request
    // already driven; ends in the IDLE cycle after the response pulse.
    task automatic serve(input logic e_acc, input logic e_wr, input logic [15:0] e_addr,
                         input logic [31:0] e_wd, input logic drop);
        logic [3:0] exp_pulse;
        exp_pulse = e_wr ? (e_acc ? 4'b0001 : 4'b0100) : (e_acc ? 4'b0010 : 4'b1000);
        tick();
        chk("issue_strobes", {mem_read_en, mem_write_en}, e_wr ? 2'b01 : 2'b10);
        chk("issue_addr", mem_addr, e_addr);
        if (e_wr) chk("issue_wdata", mem_write_data, e_wd);
        chk("issue_pulses", pulses(), 4'b0000);
        tick();
        chk("post_issue_strobes", {mem_read_en, mem_write_en}, 2'b00);
        if (!e_wr) begin
            chk("capture_pulses", pulses(), 4'b0000);
            tick();
            last_line = line_for(e_addr);
        end
        chk("resp_pulse", pulses(), exp_pulse);
        chk("resp_line", client_read_data, last_line);
        tick();
        chk("idle_outputs", {pulses(), mem_read_en, mem_write_en}, 6'b0);
        if (drop) begin
            if (e_acc) begin acc_read_en = 1'b0; acc_write_en = 1'b0; end
            else       begin cpu_read_en = 1'b0; cpu_write_en = 1'b0; end
        end
    endtask

    typedef struct {
        logic        cpu_rd, cpu_wr;
        logic [15:0] cpu_a;
        logic [31:0] cpu_d;
        logic        acc_rd, acc_wr;
        logic [15:0] acc_a;
        logic [31:0] acc_d;
        logic        first_acc, first_wr, second_wr;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic both;

        vecs[0] = '{1'b1, 1'b0, 16'h1000, 32'h0,        1'b0, 1'b0, 16'h0,    32'h0,        1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 16'h0,    32'h0,        1'b0, 1'b1, 16'h5000, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'h2000, 32'h0,        1'b1, 1'b0, 16'h3000, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 16'h0123, 32'h11112222, 1'b0, 1'b0, 16'h0,    32'h0,        1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 16'h0,    32'h0,        1'b1, 1'b1, 16'h7FFF, 32'h0BADCAFE, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 16'h00FF, 32'hCAFEF00D, 1'b0, 1'b1, 16'h4444, 32'h12345678, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 16'h0,    32'h0,        1'b1, 1'b0, 16'hFFFF, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 16'h1000, 32'h0,        1'b0, 1'b1, 16'h0042, 32'hA5A55A5A, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        cpu_read_en = 1'b0; cpu_write_en = 1'b0; cpu_addr = '0; cpu_write_data = '0;
        acc_read_en = 1'b0; acc_write_en = 1'b0; acc_addr = '0; acc_write_data = '0;
        last_line = '0;
        tick();
        tick();
        chk("reset_outputs", all_outs(), 54'b0);
        chk("reset_line", client_read_data, 512'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_no_request", all_outs(), 54'b0);
        end

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            cpu_read_en = v.cpu_rd; cpu_write_en = v.cpu_wr;
            cpu_addr = v.cpu_a;     cpu_write_data = v.cpu_d;
            acc_read_en = v.acc_rd; acc_write_en = v.acc_wr;
            acc_addr = v.acc_a;     acc_write_data = v.acc_d;
            both = (v.cpu_rd | v.cpu_wr) & (v.acc_rd | v.acc_wr);
            serve(v.first_acc, v.first_wr,
                  v.first_acc ? v.acc_a : v.cpu_a,
                  v.first_acc ? v.acc_d : v.cpu_d, 1'b1);
            if (both)
                serve(~v.first_acc, v.second_wr,
                      v.first_acc ? v.cpu_a : v.acc_a,
                      v.first_acc ? v.cpu_d : v.acc_d, 1'b1);
        end

        // CPU keeps re-requesting with the cluster waiting.
        cpu_read_en = 1'b1; cpu_addr = 16'h0A00;
        acc_read_en = 1'b1; acc_addr = 16'h0B00;
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
        for (int i = 0; i < 4; i++) serve(1'b0, 1'b0, 16'h0A00, 32'h0, 1'b0);
        serve(1'b1, 1'b0, 16'h0B00, 32'h0, 1'b1);
        serve(1'b0, 1'b0, 16'h0A00, 32'h0, 1'b1);
`else
        for (int i = 0; i < 6; i++) serve(1'b0, 1'b0, 16'h0A00, 32'h0, 1'b0);
        serve(1'b0, 1'b0, 16'h0A00, 32'h0, 1'b1);
        serve(1'b1, 1'b0, 16'h0B00, 32'h0, 1'b1);
`endif

        // Reset during CAPTURE aborts the read; the held request is then
        // served from scratch.
        cpu_read_en = 1'b1; cpu_addr = 16'h2222;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("abort_outputs", all_outs(), 54'b0);
        chk("abort_line", client_read_data, 512'b0);
        rst = 1'b0;
        last_line = '0;
        serve(1'b0, 1'b0, 16'h2222, 32'h0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
